// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and defaults
// for the transmitter scheduler slice.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam int DATA_W_DEF  = 10;
  localparam int TIMEOUT_DEF = 64;
  localparam int GAP_DEF     = 2;

endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// searching upward from last+1 with wrap.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic              any,
  output logic [IW-1:0]     grant
);

  // Scan farthest offset first so the
  // nearest requester after last wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_CH]) begin
        any   = 1'b1;
        grant = IW'((int'(last) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: shares one serial count
// transmitter between NUM_CH channels.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int GAP_CYCLES = GAP_DEF,
  parameter  int TIMEOUT    = TIMEOUT_DEF,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [NUM_CH-1:0]        i_req_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_req_data,
  output logic [NUM_CH-1:0]        o_req_ack,
  output logic                     o_count_valid,
  output logic [DATA_W-1:0]        o_data,
  input  logic                     i_tx_done,
  output logic [IW-1:0]            o_grant_id,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic                     o_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  state_t              state, state_n;
  logic [IW-1:0]       last, last_n;
  logic [WW-1:0]       wd, wd_n;
  logic [GW-1:0]       gap, gap_n;
  logic [NUM_CH-1:0]   ack_n;
  logic                cv_n, to_n, err_n;
  logic                busy_n;
  logic [DATA_W-1:0]   data_n;
  logic [IW-1:0]       gid_n;
  logic                any;
  logic [IW-1:0]       pick;
  state_t              after_frame;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (i_req_valid),
    .last  (last),
    .any   (any),
    .grant (pick)
  );

  assign after_frame =
    (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, counters and next outputs.
  always_comb begin
    state_n = state;
    last_n  = last;
    wd_n    = wd;
    gap_n   = gap;
    ack_n   = '0;
    cv_n    = 1'b0;
    to_n    = 1'b0;
    err_n   = o_err;
    data_n  = o_data;
    gid_n   = o_grant_id;
    unique case (state)
      S_IDLE: begin
        if (i_enable && any) begin
          data_n =
            i_req_data[int'(pick)*DATA_W +: DATA_W];
          gid_n       = pick;
          last_n      = pick;
          wd_n        = '0;
          ack_n[pick] = 1'b1;
          cv_n        = 1'b1;
          state_n     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_n    = wd + WW'(1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          gap_n   = '0;
          state_n = after_frame;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          to_n    = 1'b1;
          err_n   = 1'b1;
          gap_n   = '0;
          state_n = after_frame;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      S_GAP: begin
        if (gap == GW'(GAP_CYCLES - 1))
          state_n = S_IDLE;
        else
          gap_n = gap + GW'(1);
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // Registered outputs, pointer, counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last          <= IW'(NUM_CH - 1);
      wd            <= '0;
      gap           <= '0;
      o_req_ack     <= '0;
      o_count_valid <= 1'b0;
      o_data        <= '0;
      o_grant_id    <= '0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      last          <= last_n;
      wd            <= wd_n;
      gap           <= gap_n;
      o_req_ack     <= ack_n;
      o_count_valid <= cv_n;
      o_data        <= data_n;
      o_grant_id    <= gid_n;
      o_busy        <= busy_n;
      o_timeout     <= to_n;
      o_err         <= err_n;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed and random
// checks of the transmitter scheduler.
module tb_tx_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 10;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam int IW  = $clog2(NCH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NCH-1:0]    req_v = '0;
  logic [NCH*DW-1:0] req_d = '0;
  logic [NCH-1:0]    ack;
  logic              cv;
  logic [DW-1:0]     data;
  logic              done = 1'b0;
  logic [IW-1:0]     gid;
  logic              busy;
  logic              tout;
  logic              err;

  int checks = 0;
  int failures = 0;
  int to_count = 0;
  int m_last = NCH - 1;

  tx_scheduler #(
    .NUM_CH(NCH), .DATA_W(DW),
    .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_enable(en),
    .i_req_valid(req_v),
    .i_req_data(req_d),
    .o_req_ack(ack),
    .o_count_valid(cv),
    .o_data(data),
    .i_tx_done(done),
    .o_grant_id(gid),
    .o_busy(busy),
    .o_timeout(tout),
    .o_err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (tout === 1'b1) to_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(
    input logic [NCH-1:0] v, input int last);
    for (int k = 1; k <= NCH; k++)
      if (v[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  function automatic logic [DW-1:0] ch_data(
    input int c);
    logic [NCH*DW-1:0] d;
    d = req_d;
    return d[c*DW +: DW];
  endfunction

  task automatic set_data(input int c,
                          input int v);
    req_d[c*DW +: DW] = DW'(v);
  endtask

  // Waits for a launch, checks the model's
  // pick, ends one cycle after the launch.
  task automatic launch_check(
    input bit stale, output int waited);
    int e;
    logic [DW-1:0] ed;
    e = rr_pick(req_v, m_last);
    ed = (e >= 0) ? ch_data(e) : '0;
    waited = 0;
    while (cv !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    chk("launch_seen", 32'(cv), 1);
    chk("ack_onehot", 32'(ack), 32'(1) << e);
    chk("grant_id", 32'(gid), 32'(e));
    chk("cap_data", 32'(data), 32'(ed));
    chk("busy_launch", 32'(busy), 1);
    m_last = e;
    if (stale) done = 1'b1;
    tick();
    done = 1'b0;
    chk("cv_pulse_end", 32'(cv), 0);
    chk("ack_pulse_end", 32'(ack), 0);
  endtask

  // Returns done now; checks busy drops
  // exactly GAP+1 cycles later.
  task automatic deliver_done(input bit stale_gap);
    int n;
    done = 1'b1;
    tick();
    n = 1;
    done = 1'b0;
    if (stale_gap) begin
      done = 1'b1;
      tick();
      n = 2;
      done = 1'b0;
    end
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_fall", 32'(n), 32'(GAP + 1));
  endtask

  initial begin
    int w, n, lat, g, seen;
    int to0;
    logic [NCH-1:0] v;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_cv", 32'(cv), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(tout), 0);
    chk("rst_err", 32'(err), 0);

    // Single request on channel 2.
    set_data(2, 15);
    req_v = 4'b0100;
    launch_check(1'b0, w);
    req_v = '0;
    repeat (11) tick();
    deliver_done(1'b0);
    chk("single_hold", 32'(data), 15);

    // Stale done in LAUNCH and in GAP.
    set_data(1, 77);
    req_v = 4'b0010;
    launch_check(1'b1, w);
    req_v = '0;
    repeat (6) tick();
    chk("stale_l_busy", 32'(busy), 1);
    chk("stale_l_to", 32'(to_count), 0);
    deliver_done(1'b1);
    repeat (4) tick();
    chk("stale_g_idle", 32'(busy), 0);

    // Done collides with watchdog limit.
    set_data(0, 5);
    req_v = 4'b0001;
    launch_check(1'b0, w);
    req_v = '0;
    repeat (TO - 2) tick();
    deliver_done(1'b0);
    repeat (3) tick();
    chk("coll_no_to", 32'(to_count), 0);
    chk("coll_no_err", 32'(err), 0);

    // Async reset in the middle of WAIT_DONE.
    set_data(3, 9);
    req_v = 4'b1000;
    launch_check(1'b0, w);
    req_v = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cv", 32'(cv), 0);
    chk("arst_data", 32'(data), 0);
    chk("arst_gid", 32'(gid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_last = NCH - 1;
    seen = 0;
    repeat (5) begin
      tick();
      if (cv !== 1'b0 || ack !== '0) seen++;
    end
    chk("arst_quiet", 32'(seen), 0);

    // Continuous round-robin, all channels.
    for (int c = 0; c < NCH; c++)
      set_data(c, 100 * (c + 1));
    req_v = '1;
    for (int f = 0; f < 5; f++) begin
      launch_check(1'b0, w);
      chk("rr_order", 32'(m_last), 32'(f % NCH));
      if (f == 4) req_v = '0;
      repeat (10) tick();
      deliver_done(1'b0);
    end

    // Watchdog abort, then normal service.
    set_data(1, 321);
    req_v = 4'b0010;
    to0 = to_count;
    launch_check(1'b0, w);
    req_v = '0;
    n = 1;
    while (tout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'(TO));
    chk("to_err_set", 32'(err), 1);
    tick();
    chk("to_pulse_end", 32'(tout), 0);
    set_data(3, 654);
    req_v = 4'b1000;
    launch_check(1'b0, w);
    req_v = '0;
    repeat (4) tick();
    deliver_done(1'b0);
    chk("to_once", 32'(to_count - to0), 1);
    chk("err_sticky", 32'(err), 1);

    // Enable gating.
    en = 1'b0;
    set_data(0, 42);
    req_v = 4'b0001;
    seen = 0;
    repeat (20) begin
      tick();
      if (ack !== '0 || cv !== 1'b0) seen++;
    end
    chk("en_block", 32'(seen), 0);
    en = 1'b1;
    launch_check(1'b0, w);
    chk("en_cycles", 32'(w + 1), 2);
    req_v = 4'b0011;
    set_data(1, 43);
    repeat (2) tick();
    en = 1'b0;
    repeat (2) tick();
    deliver_done(1'b0);
    seen = 0;
    repeat (20) begin
      tick();
      if (cv !== 1'b0) seen++;
    end
    chk("en_drop_hold", 32'(seen), 0);
    chk("data_held", 32'(data), 42);
    en = 1'b1;
    launch_check(1'b0, w);
    req_v = '0;
    repeat (3) tick();
    deliver_done(1'b0);

    // Random traffic against the model.
    v = '0;
    for (int c = 0; c < NCH; c++)
      set_data(c, $urandom_range(0, 1023));
    for (int f = 0; f < 30; f++) begin
      if (v == '0) v[$urandom_range(0, NCH-1)] = 1'b1;
      req_v = v;
      launch_check(1'b0, w);
      g = m_last;
      for (int c = 0; c < NCH; c++) begin
        if (c == g) begin
          v[c] = 1'($urandom_range(0, 1));
          set_data(c, $urandom_range(0, 1023));
        end else if (!v[c] &&
                     $urandom_range(0, 3) == 0) begin
          v[c] = 1'b1;
          set_data(c, $urandom_range(0, 1023));
        end
      end
      req_v = v;
      lat = $urandom_range(1, 20);
      repeat (lat - 1) tick();
      deliver_done(1'b0);
    end
    req_v = '0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=run expected=done");
    $fatal(1, "bench time limit");
  end

endmodule
